usb_rx_ctrl: RTL and testbench
==============================

USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have port start_det, input, 1 bit: single-cycle pulse marking the first bus transition of a packet.
REQ-004 The module SHALL have port shift_en, input, 1 bit: single-cycle strobe, one per bit time, qualifying d_orig.
REQ-005 The module SHALL have port d_orig, input, 1 bit: NRZI-decoded bit value.
REQ-006 The module SHALL have port bit_stuff, input, 1 bit: high when the bit-stuff detector has counted six consecutive ones, so the next bit is a stuffed bit.
REQ-007 The module SHALL have port eop, input, 1 bit: level-high while an SE0 end-of-packet is seen on the bus.
REQ-008 The module SHALL have port det_shift_en, output, 1 bit: gated strobe to the bit-stuff detector.
REQ-009 The module SHALL have port rcv_data, output, 8 bits: last completed byte.
REQ-010 The module SHALL have port byte_valid, output, 1 bit: single-cycle pulse when rcv_data updates.
REQ-011 The module SHALL have port rcving, output, 1 bit: high from SYNC match until packet end.
REQ-012 The module SHALL have port rx_done, output, 1 bit: single-cycle pulse on a clean EOP.
REQ-013 The module SHALL have port rx_error, output, 1 bit: sticky error flag.

Function
REQ-014 The FSM SHALL have the states IDLE, SYNC, RECV, EOP_WAIT and ERROR.
REQ-015 IDLE SHALL go to SYNC on start_det and ignore shift_en; entering SYNC SHALL clear rx_error, the shift register and the bit count.
REQ-016 det_shift_en SHALL equal shift_en in SYNC and RECV, and 0 in all other states (combinational, zero latency).
REQ-017 On each accepted bit, the shift register SHALL shift right with d_orig entering bit 7 (LSB-first), and the 3-bit bit count SHALL increment, wrapping from 7 to 0.
REQ-018 SYNC: after the 8th accepted bit, a shift-register value of 8'h80 SHALL go to RECV with rcving=1; any other value SHALL go to ERROR.
REQ-019 RECV, shift_en with bit_stuff=1 and d_orig=0: the bit SHALL be discarded, with no shift and no count.
REQ-020 RECV, shift_en with bit_stuff=1 and d_orig=1: the FSM SHALL go to ERROR (stuff violation).
REQ-021 RECV, 8th accepted bit: on the next cycle, rcv_data SHALL load the shift-register value and byte_valid SHALL pulse for 1 cycle; shifting SHALL continue without a gap.
REQ-022 RECV with eop=1 and bit count 0: the FSM SHALL pulse rx_done for 1 cycle and go to EOP_WAIT.
REQ-023 RECV with eop=1 and bit count not 0: the FSM SHALL go to ERROR (partial byte).
REQ-024 If eop=1 and shift_en=1 arrive in the same cycle, eop SHALL take priority and the bit SHALL be dropped.
REQ-025 EOP_WAIT SHALL return to IDLE when eop=0; rcving SHALL clear on leaving RECV.
REQ-026 ERROR SHALL set rx_error=1 and rcving=0, wait for eop=1 and then eop=0, and then go to IDLE; rx_error SHALL stay high until the next SYNC entry.
REQ-027 start_det outside IDLE SHALL be ignored.
REQ-028 eop seen in SYNC SHALL go to ERROR.

Reset
REQ-029 While rst=1 on a clock edge, the state SHALL become IDLE and the shift register, bit count and rcv_data SHALL become 0.
REQ-030 While rst=1, byte_valid, rcving, rx_done, rx_error and det_shift_en SHALL be 0.
REQ-031 Reset asserted mid-packet SHALL abort with no byte_valid and no rx_done, and the next packet SHALL require a new start_det.

Structure
REQ-032 The shared package usb_rx_pkg SHALL hold the rx_state_t enum and the localparam SYNC_BYTE = 8'h80.
REQ-033 The bit count SHALL be one flex_counter instance (NUM_CNT_BITS=3, rollover_val=7); the 8th bit SHALL be detected as count==7 on an accepted bit.
REQ-034 No other sub-modules SHALL be used.

Verification
REQ-035 Good packet: start_det, sync bits 0,0,0,0,0,0,0,1, data byte 8'hA5 sent LSB-first, then eop with count 0 -> rcving=1 after sync, rcv_data=8'hA5 with one byte_valid, one rx_done, rx_error=0.
REQ-036 Stuffed bit: data 8'hFF sent with a stuffed 0 after the sixth 1 (bit_stuff=1) -> rcv_data=8'hFF, exactly 8 counted bits, no error.
REQ-037 Stuff violation: a 1 arrives while bit_stuff=1 -> ERROR, rx_error=1, no byte_valid; IDLE after eop 1->0.
REQ-038 Bad sync: 8'h81 is received in SYNC -> ERROR, rcving never high, rx_error=1.
REQ-039 Partial byte: eop after 5 data bits -> rx_error=1, no rx_done.
REQ-040 Simultaneous events and reset: eop coincident with shift_en -> bit dropped; rst asserted in mid-byte -> all outputs 0 on the next edge.
REQ-041 Recovery: a following good packet after REQ-040 -> clean reception.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive controller.
package usb_rx_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'h80;
    localparam logic [CNT_W-1:0]  CNT_LAST  = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        RECV,
        EOP_WAIT,
        ERROR
    } rx_state_t;

    // LSB-first deserialisation: new bit enters at the top.
    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] sr, input logic b);
        return {b, sr[BYTE_W-1:1]};
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Parameterised up-counter that wraps from rollover_val back to zero.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? '0 : count_q + NUM_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB receive control FSM: SYNC match, byte assembly with stuff-bit removal,
// EOP handling and sticky error reporting.
module usb_rx_ctrl
    import usb_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_det,
    input  logic              shift_en,
    input  logic              d_orig,
    input  logic              bit_stuff,
    input  logic              eop,
    output logic              det_shift_en,
    output logic [BYTE_W-1:0] rcv_data,
    output logic              byte_valid,
    output logic              rcving,
    output logic              rx_done,
    output logic              rx_error
);

    rx_state_t         state_q, state_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [BYTE_W-1:0] rcv_data_q, rcv_data_d;
    logic              byte_valid_q, byte_valid_d;
    logic              rcving_q, rcving_d;
    logic              rx_done_q, rx_done_d;
    logic              rx_error_q, rx_error_d;
    logic              eop_seen_q, eop_seen_d;

    logic              cnt_clear;
    logic              cnt_en;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_last;

    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_bit_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear         (cnt_clear),
        .count_enable  (cnt_en),
        .rollover_val  (CNT_LAST),
        .count_out     (cnt),
        .rollover_flag (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        rcv_data_d   = rcv_data_q;
        byte_valid_d = 1'b0;
        rx_done_d    = 1'b0;
        rcving_d     = rcving_q;
        rx_error_d   = rx_error_q;
        eop_seen_d   = eop_seen_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                rcving_d = 1'b0;
                if (start_det) begin
                    state_d    = SYNC;
                    rx_error_d = 1'b0;
                    shreg_d    = '0;
                    cnt_clear  = 1'b1;
                end
            end

            SYNC: begin
                if (eop) begin
                    state_d    = ERROR;
                    rx_error_d = 1'b1;
                    eop_seen_d = 1'b0;
                end else if (shift_en) begin
                    cnt_en  = 1'b1;
                    shreg_d = shift_in(shreg_q, d_orig);
                    if (cnt_last) begin
                        if (shreg_d == SYNC_BYTE) begin
                            state_d  = RECV;
                            rcving_d = 1'b1;
                        end else begin
                            state_d    = ERROR;
                            rx_error_d = 1'b1;
                            eop_seen_d = 1'b0;
                        end
                    end
                end
            end

            RECV: begin
                // eop outranks a coincident strobe; that bit is dropped.
                if (eop) begin
                    rcving_d = 1'b0;
                    if (cnt == '0) begin
                        state_d   = EOP_WAIT;
                        rx_done_d = 1'b1;
                    end else begin
                        state_d    = ERROR;
                        rx_error_d = 1'b1;
                        eop_seen_d = 1'b0;
                    end
                end else if (shift_en) begin
                    if (bit_stuff) begin
                        if (d_orig) begin
                            state_d    = ERROR;
                            rx_error_d = 1'b1;
                            rcving_d   = 1'b0;
                            eop_seen_d = 1'b0;
                        end
                    end else begin
                        cnt_en  = 1'b1;
                        shreg_d = shift_in(shreg_q, d_orig);
                        if (cnt_last) begin
                            rcv_data_d   = shreg_d;
                            byte_valid_d = 1'b1;
                        end
                    end
                end
            end

            EOP_WAIT: begin
                rcving_d = 1'b0;
                if (!eop) begin
                    state_d = IDLE;
                end
            end

            ERROR: begin
                rcving_d   = 1'b0;
                rx_error_d = 1'b1;
                if (eop) begin
                    eop_seen_d = 1'b1;
                end else if (eop_seen_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            rcv_data_q   <= '0;
            byte_valid_q <= 1'b0;
            rcving_q     <= 1'b0;
            rx_done_q    <= 1'b0;
            rx_error_q   <= 1'b0;
            eop_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            rcv_data_q   <= rcv_data_d;
            byte_valid_q <= byte_valid_d;
            rcving_q     <= rcving_d;
            rx_done_q    <= rx_done_d;
            rx_error_q   <= rx_error_d;
            eop_seen_q   <= eop_seen_d;
        end
    end

    assign det_shift_en = shift_en & ~rst & ((state_q == SYNC) || (state_q == RECV));
    assign rcv_data     = rcv_data_q;
    assign byte_valid   = byte_valid_q;
    assign rcving       = rcving_q;
    assign rx_done      = rx_done_q;
    assign rx_error     = rx_error_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl: received bytes are checked against a queue
// of expected bytes; packet-level outcomes are checked after each packet.
module tb_usb_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_det;
    logic       shift_en;
    logic       d_orig;
    logic       bit_stuff;
    logic       eop;
    logic       det_shift_en;
    logic [7:0] rcv_data;
    logic       byte_valid;
    logic       rcving;
    logic       rx_done;
    logic       rx_error;

    int n_cmp = 0;
    int n_err = 0;
    int bv_cnt = 0;
    int done_cnt = 0;
    bit rcving_seen = 1'b0;
    logic [7:0] exp_q[$];

    usb_rx_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_det    (start_det),
        .shift_en     (shift_en),
        .d_orig       (d_orig),
        .bit_stuff    (bit_stuff),
        .eop          (eop),
        .det_shift_en (det_shift_en),
        .rcv_data     (rcv_data),
        .byte_valid   (byte_valid),
        .rcving       (rcving),
        .rx_done      (rx_done),
        .rx_error     (rx_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every byte_valid pops one expected byte.
    always @(negedge clk) begin
        if (byte_valid) begin
            bv_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_byte_valid", 32'(rcv_data), 32'hFFFF_FFFF);
            end else begin
                chk("rcv_data", 32'(rcv_data), 32'(exp_q.pop_front()));
            end
        end
        if (rx_done) done_cnt++;
        if (rcving) rcving_seen = 1'b1;
    end

    task automatic send_bit(input logic d, input logic stuff, input logic exp_det);
        @(posedge clk); #1;
        shift_en  = 1'b1;
        d_orig    = d;
        bit_stuff = stuff;
        #2;
        chk("det_shift_en", 32'(det_shift_en), 32'(exp_det));
        @(posedge clk); #1;
        shift_en  = 1'b0;
        bit_stuff = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_det);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i], 1'b0, exp_det);
        end
    endtask

    task automatic start_pkt();
        @(posedge clk); #1;
        start_det = 1'b1;
        @(posedge clk); #1;
        start_det = 1'b0;
    endtask

    task automatic eop_pulse();
        @(posedge clk); #1;
        eop = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        eop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    int bv0, done0;

    initial begin
        rst = 1'b1; start_det = 1'b0; shift_en = 1'b1; d_orig = 1'b0;
        bit_stuff = 1'b0; eop = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        sample();
        chk("rst_det_shift_en", 32'(det_shift_en), 32'd0);
        chk("rst_rcv_data",     32'(rcv_data),     32'd0);
        chk("rst_byte_valid",   32'(byte_valid),   32'd0);
        chk("rst_rcving",       32'(rcving),       32'd0);
        chk("rst_rx_done",      32'(rx_done),      32'd0);
        chk("rst_rx_error",     32'(rx_error),     32'd0);
        @(posedge clk); #1;
        rst = 1'b0; shift_en = 1'b0;

        // IDLE ignores shift_en
        send_bit(1'b1, 1'b0, 1'b0);

        // Good packet 8'hA5
        bv0 = bv_cnt; done0 = done_cnt;
        start_pkt();
        send_byte(8'h80, 1'b1);
        sample();
        chk("good_rcving", 32'(rcving), 32'd1);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        eop_pulse();
        sample();
        chk("good_bv_count",  32'(bv_cnt - bv0),     32'd1);
        chk("good_done_count", 32'(done_cnt - done0), 32'd1);
        chk("good_rx_error",  32'(rx_error),         32'd0);
        chk("good_rcving_end", 32'(rcving),          32'd0);
        chk("good_rcv_data",  32'(rcv_data),         32'hA5);

        // Stuffed zero inside 8'hFF
        bv0 = bv_cnt; done0 = done_cnt;
        start_pkt();
        send_byte(8'h80, 1'b1);
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        eop_pulse();
        sample();
        chk("stuff_bv_count",   32'(bv_cnt - bv0),     32'd1);
        chk("stuff_done_count", 32'(done_cnt - done0), 32'd1);
        chk("stuff_rx_error",   32'(rx_error),         32'd0);
        chk("stuff_rcv_data",   32'(rcv_data),         32'hFF);

        // Stuff violation
        bv0 = bv_cnt; done0 = done_cnt;
        start_pkt();
        send_byte(8'h80, 1'b1);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b1, 1'b1);
        sample();
        chk("viol_rx_error", 32'(rx_error), 32'd1);
        chk("viol_rcving",   32'(rcving),   32'd0);
        send_bit(1'b0, 1'b0, 1'b0);
        eop_pulse();
        sample();
        chk("viol_bv_count",   32'(bv_cnt - bv0),     32'd0);
        chk("viol_done_count", 32'(done_cnt - done0), 32'd0);
        chk("viol_error_sticky", 32'(rx_error),       32'd1);
        start_pkt();
        sample();
        chk("viol_error_cleared", 32'(rx_error), 32'd0);
        eop_pulse();

        // Bad sync 8'h81
        rcving_seen = 1'b0;
        start_pkt();
        send_byte(8'h81, 1'b1);
        sample();
        chk("badsync_rx_error", 32'(rx_error), 32'd1);
        eop_pulse();
        sample();
        chk("badsync_rcving_never", 32'(rcving_seen), 32'd0);

        // Partial byte: eop after 5 data bits
        bv0 = bv_cnt; done0 = done_cnt;
        start_pkt();
        send_byte(8'h80, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b1);
        eop_pulse();
        sample();
        chk("partial_rx_error",   32'(rx_error),         32'd1);
        chk("partial_done_count", 32'(done_cnt - done0), 32'd0);
        chk("partial_bv_count",   32'(bv_cnt - bv0),     32'd0);

        // eop coincident with the 8th bit strobe: bit is dropped
        bv0 = bv_cnt; done0 = done_cnt;
        start_pkt();
        send_byte(8'h80, 1'b1);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        eop = 1'b1; shift_en = 1'b1; d_orig = 1'b1;
        @(posedge clk); #1;
        shift_en = 1'b0;
        eop_pulse();
        sample();
        chk("coinc_bv_count",   32'(bv_cnt - bv0),     32'd0);
        chk("coinc_done_count", 32'(done_cnt - done0), 32'd0);
        chk("coinc_rx_error",   32'(rx_error),         32'd1);

        // Reset mid-byte
        bv0 = bv_cnt; done0 = done_cnt;
        start_pkt();
        send_byte(8'h80, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; shift_en = 1'b1;
        @(posedge clk);
        sample();
        chk("midrst_det_shift_en", 32'(det_shift_en), 32'd0);
        chk("midrst_rcving",       32'(rcving),       32'd0);
        chk("midrst_rcv_data",     32'(rcv_data),     32'd0);
        chk("midrst_byte_valid",   32'(byte_valid),   32'd0);
        chk("midrst_rx_done",      32'(rx_done),      32'd0);
        chk("midrst_rx_error",     32'(rx_error),     32'd0);
        @(posedge clk); #1;
        rst = 1'b0; shift_en = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
        eop_pulse();
        sample();
        chk("midrst_bv_count",   32'(bv_cnt - bv0),     32'd0);
        chk("midrst_done_count", 32'(done_cnt - done0), 32'd0);

        // Recovery: two-byte good packet
        bv0 = bv_cnt; done0 = done_cnt;
        start_pkt();
        send_byte(8'h80, 1'b1);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 1'b1);
        eop_pulse();
        sample();
        chk("recov_bv_count",   32'(bv_cnt - bv0),     32'd2);
        chk("recov_done_count", 32'(done_cnt - done0), 32'd1);
        chk("recov_rx_error",   32'(rx_error),         32'd0);
        chk("recov_rcv_data",   32'(rcv_data),         32'hC3);
        chk("scoreboard_empty", 32'(exp_q.size()),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
